inst_ram_loader: RTL and testbench

Boot-time loader for the 32x512 instruction SRAM. It takes a byte stream from the UART receiver, assembles little-endian 32-bit words, and writes them through the SRAM read/write port (port 0) while the core fetches only on port 1. It holds the core in reset until the image is loaded and its checksum passes. It latches an error state if the length or checksum is bad.

---
 rtl/inst_ram_loader_if.sv | 23 ++
 rtl/inst_ram_loader.sv | 157 +++++++++++++++
 tb/tb_inst_ram_loader.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/inst_ram_loader_if.sv
// Loader bus: UART byte stream in, SRAM port-0 write strobe out.
// The loader connects through master; the byte source / SRAM side uses slave.
interface inst_ram_loader_if #(
   parameter int ADDR_W = 9
);
   logic              rx_valid;
   logic [7:0]        rx_data;
   logic              csb0;
   logic              web0;
   logic [3:0]        wmask0;
   logic [ADDR_W-1:0] addr0;
   logic [31:0]       din0;

   modport master (
      input  rx_valid, rx_data,
      output csb0, web0, wmask0, addr0, din0
   );

   modport slave (
      output rx_valid, rx_data,
      input  csb0, web0, wmask0, addr0, din0
   );
endinterface

// File: rtl/inst_ram_loader.sv
// Boot loader: parses a length-prefixed byte image, writes little-endian words to
// SRAM port 0, and releases the core only after the XOR checksum matches.
module inst_ram_loader #(
   parameter int ADDR_W    = 9,
   parameter int MAX_WORDS = 512
) (
   input  logic              clk,
   input  logic              rst,
   inst_ram_loader_if.master bus,
   output logic              cpu_rst,
   output logic              load_done,
   output logic              load_err
);
   typedef enum logic [2:0] {LEN_LO, LEN_HI, DATA, CSUM, DONE, ERR} state_t;

   state_t            state_reg, state_next;
   logic [7:0]        len_lo_reg, len_lo_next;
   logic [15:0]       n_reg, n_next;
   logic [15:0]       cnt_reg, cnt_next;
   logic [1:0]        idx_reg, idx_next;
   logic [7:0]        csum_reg, csum_next;
   logic [7:0]        lane_reg [3];
   logic [7:0]        lane_next [3];
   logic              csb0_reg, csb0_next;
   logic              web0_reg, web0_next;
   logic [3:0]        wmask0_reg, wmask0_next;
   logic [ADDR_W-1:0] addr0_reg, addr0_next;
   logic [31:0]       din0_reg, din0_next;
   logic              cpu_rst_reg, cpu_rst_next;
   logic              done_reg, done_next;
   logic              err_reg, err_next;

   logic [15:0]       len_word;
   logic              data_byte;

   assign len_word  = {bus.rx_data, len_lo_reg};
   assign data_byte = (state_reg == DATA) && bus.rx_valid;

   // Only lanes 0..2 are stored; lane 3 is taken straight from rx_data when the word completes.
   generate
      for (genvar gi = 0; gi < 3; gi++) begin : g_lane
         assign lane_next[gi] = (data_byte && idx_reg == 2'(gi)) ? bus.rx_data : lane_reg[gi];
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg   <= LEN_LO;
         len_lo_reg  <= 8'h00;
         n_reg       <= 16'h0000;
         cnt_reg     <= 16'h0000;
         idx_reg     <= 2'd0;
         csum_reg    <= 8'h00;
         for (int i = 0; i < 3; i++) lane_reg[i] <= 8'h00;
         csb0_reg    <= 1'b1;
         web0_reg    <= 1'b1;
         wmask0_reg  <= 4'h0;
         addr0_reg   <= '0;
         din0_reg    <= 32'h0;
         cpu_rst_reg <= 1'b1;
         done_reg    <= 1'b0;
         err_reg     <= 1'b0;
      end else begin
         state_reg   <= state_next;
         len_lo_reg  <= len_lo_next;
         n_reg       <= n_next;
         cnt_reg     <= cnt_next;
         idx_reg     <= idx_next;
         csum_reg    <= csum_next;
         for (int i = 0; i < 3; i++) lane_reg[i] <= lane_next[i];
         csb0_reg    <= csb0_next;
         web0_reg    <= web0_next;
         wmask0_reg  <= wmask0_next;
         addr0_reg   <= addr0_next;
         din0_reg    <= din0_next;
         cpu_rst_reg <= cpu_rst_next;
         done_reg    <= done_next;
         err_reg     <= err_next;
      end
   end

   always_comb begin
      state_next  = state_reg;
      len_lo_next = len_lo_reg;
      n_next      = n_reg;
      cnt_next    = cnt_reg;
      idx_next    = idx_reg;
      csum_next   = csum_reg;
      csb0_next   = 1'b1;
      web0_next   = 1'b1;
      wmask0_next = 4'h0;
      addr0_next  = addr0_reg;
      din0_next   = din0_reg;

      case (state_reg)
         LEN_LO: begin
            if (bus.rx_valid) begin
               len_lo_next = bus.rx_data;
               state_next  = LEN_HI;
            end
         end
         LEN_HI: begin
            if (bus.rx_valid) begin
               n_next    = len_word;
               cnt_next  = 16'h0000;
               idx_next  = 2'd0;
               csum_next = 8'h00;
               if (len_word > 16'(MAX_WORDS))
                  state_next = ERR;
               else if (len_word == 16'h0000)
                  state_next = CSUM;
               else
                  state_next = DATA;
            end
         end
         DATA: begin
            if (bus.rx_valid) begin
               csum_next = csum_reg ^ bus.rx_data;
               idx_next  = idx_reg + 2'd1;
               // Word complete: register a one-cycle strobe and count the word now,
               // so a byte arriving during the strobe already lands in the next word.
               if (idx_reg == 2'd3) begin
                  csb0_next   = 1'b0;
                  web0_next   = 1'b0;
                  wmask0_next = 4'hF;
                  addr0_next  = cnt_reg[ADDR_W-1:0];
                  din0_next   = {bus.rx_data, lane_reg[2], lane_reg[1], lane_reg[0]};
                  cnt_next    = cnt_reg + 16'd1;
                  if (cnt_reg + 16'd1 == n_reg)
                     state_next = CSUM;
               end
            end
         end
         CSUM: begin
            if (bus.rx_valid)
               state_next = (bus.rx_data == csum_reg) ? DONE : ERR;
         end
         DONE:    state_next = DONE;
         ERR:     state_next = ERR;
         default: state_next = ERR;
      endcase

      // Status flags track the state being entered so they appear with it.
      cpu_rst_next = (state_next != DONE);
      done_next    = (state_next == DONE);
      err_next     = (state_next == ERR);
   end

   assign bus.csb0   = csb0_reg;
   assign bus.web0   = web0_reg;
   assign bus.wmask0 = wmask0_reg;
   assign bus.addr0  = addr0_reg;
   assign bus.din0   = din0_reg;
   assign cpu_rst    = cpu_rst_reg;
   assign load_done  = done_reg;
   assign load_err   = err_reg;
endmodule

// File: tb/tb_inst_ram_loader.sv
// Self-checking bench for inst_ram_loader: fixed vector table, hand-written corner
// sequences and random images checked against a stream-level reference model.
module tb_inst_ram_loader;
   logic clk = 1'b0;
   logic rst;
   logic cpu_rst, load_done, load_err;

   inst_ram_loader_if #(.ADDR_W(9)) bus ();

   inst_ram_loader #(.ADDR_W(9), .MAX_WORDS(512)) dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus),
      .cpu_rst   (cpu_rst),
      .load_done (load_done),
      .load_err  (load_err)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Observed writes {addr0, din0} and protocol violations seen by the monitor.
   logic [40:0] obs_q [$];
   logic [40:0] exp_q [$];
   int          exp_verdict;   // 0 = still loading, 1 = done, 2 = error
   int          bad_strobe = 0;
   int          both_flags = 0;
   logic        prev_sel = 1'b0;

   initial begin
      forever begin
         @(negedge clk);
         if (bus.csb0 === 1'b0) begin
            obs_q.push_back({bus.addr0, bus.din0});
            if (bus.web0 !== 1'b0 || bus.wmask0 !== 4'hF || prev_sel) bad_strobe++;
         end else if (bus.web0 !== 1'b1 || bus.wmask0 !== 4'h0) begin
            bad_strobe++;
         end
         if (load_done === 1'b1 && load_err === 1'b1) both_flags++;
         prev_sel = (bus.csb0 === 1'b0);
      end
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference: decode the byte stream directly into the list of words and the verdict.
   function automatic void model(input logic [7:0] s[$]);
      int unsigned n;
      logic [7:0]  cs;
      exp_q.delete();
      exp_verdict = 0;
      if (s.size() < 2) return;
      n = {s[1], s[0]};
      if (n > 512) begin
         exp_verdict = 2;
         return;
      end
      cs = 8'h00;
      for (int i = 0; i < int'(n); i++) begin
         if (2 + 4*i + 3 >= s.size()) return;
         exp_q.push_back({9'(i), s[2+4*i+3], s[2+4*i+2], s[2+4*i+1], s[2+4*i]});
         cs = cs ^ s[2+4*i] ^ s[2+4*i+1] ^ s[2+4*i+2] ^ s[2+4*i+3];
      end
      if (2 + 4*int'(n) < s.size())
         exp_verdict = (s[2+4*n] == cs) ? 1 : 2;
   endfunction

   task automatic do_reset();
      rst = 1'b1;
      bus.rx_valid = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      obs_q.delete();
      bad_strobe = 0;
      both_flags = 0;
   endtask

   task automatic send(input logic [7:0] s[$], input int gap_max);
      foreach (s[i]) begin
         repeat ($urandom_range(gap_max, 0)) begin
            bus.rx_valid = 1'b0;
            bus.rx_data  = 8'($urandom);
            @(negedge clk);
         end
         bus.rx_valid = 1'b1;
         bus.rx_data  = s[i];
         @(negedge clk);
      end
      bus.rx_valid = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   task automatic compare_model(input string name);
      int m;
      check({name, " nwrites"}, 64'(obs_q.size()), 64'(exp_q.size()));
      m = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
      for (int i = 0; i < m; i++)
         check({name, " write"}, 64'(obs_q[i]), 64'(exp_q[i]));
      check({name, " load_done"}, 64'(load_done), 64'(exp_verdict == 1));
      check({name, " load_err"},  64'(load_err),  64'(exp_verdict == 2));
      check({name, " cpu_rst"},   64'(cpu_rst),   64'(exp_verdict != 1));
      check({name, " strobe_shape"}, 64'(bad_strobe), 64'd0);
      check({name, " flags_exclusive"}, 64'(both_flags), 64'd0);
      $display("stream %s: %0d writes, done=%0b err=%0b", name, obs_q.size(), load_done, load_err);
   endtask

   typedef struct {
      string       name;
      logic [7:0]  b [16];
      int          n;
      int          nwr;
      logic [31:0] w0;
      logic [31:0] w1;
      logic        done;
      logic        err;
   } vec_t;

   vec_t vt [7];

   initial begin
      logic [7:0] s [$];
      logic [7:0] b;
      logic [7:0] cs;
      int         n;

      vt[0].name = "nominal";
      vt[0].b = '{8'h02,8'h00,8'h01,8'h02,8'h03,8'h04,8'h05,8'h06,8'h07,8'h08,8'h08,8'hAA,8'hBB,8'h55,8'hCC,8'h00};
      vt[0].n = 15; vt[0].nwr = 2; vt[0].w0 = 32'h04030201; vt[0].w1 = 32'h08070605;
      vt[0].done = 1'b1; vt[0].err = 1'b0;
      vt[1].name = "bad_csum";
      vt[1].b = '{8'h02,8'h00,8'h01,8'h02,8'h03,8'h04,8'h05,8'h06,8'h07,8'h08,8'h09,8'h11,8'h22,8'h33,8'h44,8'h00};
      vt[1].n = 15; vt[1].nwr = 2; vt[1].w0 = 32'h04030201; vt[1].w1 = 32'h08070605;
      vt[1].done = 1'b0; vt[1].err = 1'b1;
      vt[2].name = "oversize";
      vt[2].b = '{8'h01,8'h02,8'h00,8'h00,8'h11,8'h22,8'h33,8'h44,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00};
      vt[2].n = 8; vt[2].nwr = 0; vt[2].w0 = 32'h0; vt[2].w1 = 32'h0;
      vt[2].done = 1'b0; vt[2].err = 1'b1;
      vt[3].name = "empty";
      vt[3].b = '{8'h00,8'h00,8'h00,8'h12,8'h34,8'h56,8'h78,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00};
      vt[3].n = 7; vt[3].nwr = 0; vt[3].w0 = 32'h0; vt[3].w1 = 32'h0;
      vt[3].done = 1'b1; vt[3].err = 1'b0;
      vt[4].name = "empty_bad";
      vt[4].b = '{8'h00,8'h00,8'h01,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00};
      vt[4].n = 3; vt[4].nwr = 0; vt[4].w0 = 32'h0; vt[4].w1 = 32'h0;
      vt[4].done = 1'b0; vt[4].err = 1'b1;
      vt[5].name = "one_word";
      vt[5].b = '{8'h01,8'h00,8'hDE,8'hAD,8'hBE,8'hEF,8'h22,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00};
      vt[5].n = 7; vt[5].nwr = 1; vt[5].w0 = 32'hEFBEADDE; vt[5].w1 = 32'h0;
      vt[5].done = 1'b1; vt[5].err = 1'b0;
      vt[6].name = "one_word_bad";
      vt[6].b = '{8'h01,8'h00,8'hDE,8'hAD,8'hBE,8'hEF,8'h23,8'h01,8'h02,8'h03,8'h04,8'h00,8'h00,8'h00,8'h00,8'h00};
      vt[6].n = 11; vt[6].nwr = 1; vt[6].w0 = 32'hEFBEADDE; vt[6].w1 = 32'h0;
      vt[6].done = 1'b0; vt[6].err = 1'b1;

      rst = 1'b1;
      bus.rx_valid = 1'b0;
      bus.rx_data  = 8'h00;
      repeat (2) @(negedge clk);
      check("reset csb0",   64'(bus.csb0),   64'd1);
      check("reset web0",   64'(bus.web0),   64'd1);
      check("reset wmask0", 64'(bus.wmask0), 64'd0);
      check("reset addr0",  64'(bus.addr0),  64'd0);
      check("reset din0",   64'(bus.din0),   64'd0);
      check("reset cpu_rst", 64'(cpu_rst),   64'd1);
      check("reset load_done", 64'(load_done), 64'd0);
      check("reset load_err",  64'(load_err),  64'd0);

      // Fixed vectors with constant expectations.
      for (int v = 0; v < 7; v++) begin
         do_reset();
         s.delete();
         for (int i = 0; i < vt[v].n; i++) s.push_back(vt[v].b[i]);
         send(s, 2);
         check({vt[v].name, " nwrites"}, 64'(obs_q.size()), 64'(vt[v].nwr));
         if (vt[v].nwr >= 1 && obs_q.size() >= 1)
            check({vt[v].name, " word0"}, 64'(obs_q[0]), 64'({9'd0, vt[v].w0}));
         if (vt[v].nwr >= 2 && obs_q.size() >= 2)
            check({vt[v].name, " word1"}, 64'(obs_q[1]), 64'({9'd1, vt[v].w1}));
         check({vt[v].name, " load_done"}, 64'(load_done), 64'(vt[v].done));
         check({vt[v].name, " load_err"},  64'(load_err),  64'(vt[v].err));
         check({vt[v].name, " cpu_rst"},   64'(cpu_rst),   64'(!vt[v].done));
         check({vt[v].name, " strobe_shape"}, 64'(bad_strobe), 64'd0);
         $display("vector %s: %0d writes, done=%0b err=%0b", vt[v].name, obs_q.size(), load_done, load_err);
      end

      // Back-to-back nominal stream.
      do_reset();
      s.delete();
      for (int i = 0; i < 11; i++) s.push_back(vt[0].b[i]);
      model(s);
      send(s, 0);
      compare_model("back_to_back");

      // Maximum image, back-to-back, correct checksum.
      do_reset();
      s = '{8'h00, 8'h02};
      cs = 8'h00;
      for (int i = 0; i < 2048; i++) begin
         b = 8'($urandom);
         cs ^= b;
         s.push_back(b);
      end
      s.push_back(cs);
      model(s);
      send(s, 0);
      compare_model("max_512");
      if (obs_q.size() > 0)
         check("max_512 last addr", 64'(obs_q[obs_q.size()-1][40:32]), 64'h1FF);

      // Reset after six data bytes, then a fresh nominal load.
      do_reset();
      s.delete();
      for (int i = 0; i < 8; i++) s.push_back(vt[0].b[i]);
      send(s, 0);
      check("midreset first write", 64'(obs_q.size()), 64'd1);
      rst = 1'b1;
      @(negedge clk);
      check("midreset csb0",   64'(bus.csb0),   64'd1);
      check("midreset web0",   64'(bus.web0),   64'd1);
      check("midreset wmask0", 64'(bus.wmask0), 64'd0);
      check("midreset addr0",  64'(bus.addr0),  64'd0);
      check("midreset din0",   64'(bus.din0),   64'd0);
      check("midreset cpu_rst", 64'(cpu_rst),   64'd1);
      check("midreset flags",  64'({load_done, load_err}), 64'd0);
      rst = 1'b0;
      obs_q.delete();
      bad_strobe = 0;
      both_flags = 0;
      s.delete();
      for (int i = 0; i < 11; i++) s.push_back(vt[0].b[i]);
      model(s);
      send(s, 1);
      compare_model("after_midreset");

      // Random images: mostly valid lengths, some oversize, some corrupted checksums.
      for (int r = 0; r < 40; r++) begin
         do_reset();
         n = ($urandom_range(9, 0) == 0) ? int'($urandom_range(65535, 513)) : int'($urandom_range(8, 0));
         s = '{8'(n), 8'(n >> 8)};
         cs = 8'h00;
         if (n <= 512) begin
            for (int i = 0; i < 4*n; i++) begin
               b = 8'($urandom);
               cs ^= b;
               s.push_back(b);
            end
            s.push_back(($urandom_range(3, 0) == 0) ? 8'(cs ^ 8'($urandom_range(255, 1))) : cs);
         end
         for (int i = 0; i < int'($urandom_range(6, 0)); i++) s.push_back(8'($urandom));
         model(s);
         send(s, 3);
         compare_model($sformatf("random_%0d", r));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
